// File: rtl/lock_sup_pkg.sv
// Shared definitions for the lock supervisor slice.
//   state_t     : supervisor FSM state encoding
//   DEF_CODE_W  : default code length (matches the serial lock)
//   DEF_SECRET  : default secret used by benches
//   max2        : elaboration-time helper for sizing timers
package lock_sup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam int         DEF_CODE_W = 7;
    localparam logic [6:0] DEF_SECRET = 7'b1011000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_supervisor_if.sv
// Code-offer handshake between a requester and the lock supervisor.
//   code_valid : code offered (master -> slave)
//   code_data  : parallel code, MSB is shifted first (master -> slave)
//   code_ready : supervisor can accept a code (slave -> master)
interface lock_supervisor_if #(
    parameter int CODE_W = 7
) ();
    logic              code_valid;
    logic [CODE_W-1:0] code_data;
    logic              code_ready;

    modport master (output code_valid, output code_data, input code_ready);
    modport slave  (input code_valid, input code_data, output code_ready);
endinterface

// File: rtl/lock_sup_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT windows.
//   clk, resetn : clock, async active-low reset
//   load, value : load value on the next edge (load wins over tick)
//   tick        : decrement by one, holding at zero (never wraps)
//   expired     : count is in its final cycle (<=1)
module lock_sup_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [TW-1:0] value,
    input  logic          tick,
    output logic          expired
);
    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                 cnt <= '0;
        else if (load)               cnt <= value;
        else if (tick && cnt != '0)  cnt <= cnt - 1'b1;
    end

    // A window loaded with N stays open for exactly N cycles: the exit is
    // taken on the edge that ends the cycle in which the count reads 1.
    assign expired = (cnt <= TW'(1));
endmodule

// File: rtl/lock_supervisor.sv
// Sequences the serial combination lock: accepts a parallel code, shifts it
// MSB-first into the lock, judges the outcome, holds the door open for a
// bounded time and imposes a lockout after MAX_FAILS consecutive failures.
// Optional feature macro: LOCKOUT_ESCALATE_EN (lockout doubles per entry).
// Ports:
//   clk, resetn              : clock, async active-low reset
//   code (slave)             : code_valid/code_data/code_ready handshake
//   relock                   : close early while OPEN
//   lock_in, lock_rstn       : drive the lock IN and resetn (registered)
//   lock_error, lock_unlock  : lock ERROR / UNLOCK
//   unlocked, alarm          : OPEN / LOCKOUT indicators
//   attempt_done, attempt_ok : one-cycle judgement pulse and its result
//   fail_count               : consecutive failures, saturating
module lock_supervisor
    import lock_sup_pkg::*;
#(
    parameter int CODE_W         = DEF_CODE_W,
    parameter int MAX_FAILS      = 3,
    parameter int OPEN_CYCLES    = 16,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         resetn,
    lock_supervisor_if.slave             code,
    input  logic                         relock,
    output logic                         lock_in,
    output logic                         lock_rstn,
    input  logic                         lock_error,
    input  logic                         lock_unlock,
    output logic                         unlocked,
    output logic                         alarm,
    output logic                         attempt_done,
    output logic                         attempt_ok,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);
    localparam int FCW = $clog2(MAX_FAILS + 1);
    localparam int KW  = $clog2(CODE_W);
`ifdef LOCKOUT_ESCALATE_EN
    localparam int LOCK_MAX = LOCKOUT_CYCLES * 8;
`else
    localparam int LOCK_MAX = LOCKOUT_CYCLES;
`endif
    localparam int TW = $clog2(max2(OPEN_CYCLES, LOCK_MAX) + 1);

    localparam logic [FCW-1:0] MAXF  = FCW'(MAX_FAILS);
    localparam logic [KW-1:0]  KLAST = KW'(CODE_W - 1);

    state_t            state;
    logic [CODE_W-1:0] sr;
    logic [KW-1:0]     k;

    logic              chk_ok, do_fail, to_lock;
    logic [FCW-1:0]    fail_nxt;
    logic              tmr_load, tmr_tick, tmr_expired;
    logic [TW-1:0]     tmr_val, lock_len;

`ifdef LOCKOUT_ESCALATE_EN
    logic [1:0]        esc_lvl;
    assign lock_len = TW'(LOCKOUT_CYCLES) << esc_lvl;
`else
    assign lock_len = TW'(LOCKOUT_CYCLES);
`endif

    // Decisions shared by the FSM and the timer load so both act on the
    // same edge.
    always_comb begin
        chk_ok   = lock_unlock & ~lock_error;
        do_fail  = ((state == ST_SEND) && lock_error) ||
                   ((state == ST_CHECK) && !chk_ok);
        fail_nxt = (fail_count == MAXF) ? fail_count : fail_count + 1'b1;
        to_lock  = do_fail && (fail_nxt == MAXF);
        tmr_load = ((state == ST_CHECK) && chk_ok) || to_lock;
        tmr_val  = to_lock ? lock_len : TW'(OPEN_CYCLES);
        tmr_tick = (state == ST_OPEN) || (state == ST_LOCKOUT);
    end

    lock_sup_timer #(.TW(TW)) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .load    (tmr_load),
        .value   (tmr_val),
        .tick    (tmr_tick),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            sr           <= '0;
            k            <= '0;
            lock_in      <= 1'b0;
            lock_rstn    <= 1'b0;
            attempt_done <= 1'b0;
            attempt_ok   <= 1'b0;
            fail_count   <= '0;
`ifdef LOCKOUT_ESCALATE_EN
            esc_lvl      <= 2'd0;
`endif
        end else begin
            attempt_done <= 1'b0;
            attempt_ok   <= 1'b0;
            if (do_fail) begin
                attempt_done <= 1'b1;
                fail_count   <= fail_nxt;
                lock_rstn    <= 1'b0;
                lock_in      <= 1'b0;
                state        <= to_lock ? ST_LOCKOUT : ST_IDLE;
`ifdef LOCKOUT_ESCALATE_EN
                if (to_lock && esc_lvl != 2'd3) esc_lvl <= esc_lvl + 2'd1;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        // code_ready is high exactly in IDLE.
                        if (code.code_valid) begin
                            lock_in   <= code.code_data[CODE_W-1];
                            sr        <= {code.code_data[CODE_W-2:0], 1'b0};
                            lock_rstn <= 1'b1;
                            k         <= '0;
                            state     <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (k == KLAST) begin
                            lock_in <= 1'b0;
                            state   <= ST_CHECK;
                        end else begin
                            lock_in <= sr[CODE_W-1];
                            sr      <= {sr[CODE_W-2:0], 1'b0};
                            k       <= k + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        // Only reached here on success; failures took do_fail.
                        attempt_done <= 1'b1;
                        attempt_ok   <= 1'b1;
                        fail_count   <= '0;
                        state        <= ST_OPEN;
`ifdef LOCKOUT_ESCALATE_EN
                        esc_lvl      <= 2'd0;
`endif
                    end
                    ST_OPEN: begin
                        if (relock || tmr_expired) begin
                            lock_rstn <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    ST_LOCKOUT: begin
                        if (tmr_expired) begin
                            fail_count <= '0;
                            state      <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign code.code_ready = (state == ST_IDLE);
    assign unlocked        = (state == ST_OPEN);
    assign alarm           = (state == ST_LOCKOUT);
endmodule

// File: tb/tb_lock_supervisor.sv
// Directed bench for lock_supervisor with a behavioural serial lock
// (secret 7'b1011000, MSB first, registered ERROR/UNLOCK, 2-cycle error
// recovery, async reset on lock_rstn).
module tb_lock_supervisor;
    import lock_sup_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       relock = 1'b0;
    logic       lock_in, lock_rstn, lock_error, lock_unlock;
    logic       unlocked, alarm, attempt_done, attempt_ok;
    logic [1:0] fail_count;
    int         total = 0;
    int         bad = 0;

    lock_supervisor_if #(.CODE_W(7)) cif ();

    lock_supervisor dut (
        .clk          (clk),
        .resetn       (resetn),
        .code         (cif.slave),
        .relock       (relock),
        .lock_in      (lock_in),
        .lock_rstn    (lock_rstn),
        .lock_error   (lock_error),
        .lock_unlock  (lock_unlock),
        .unlocked     (unlocked),
        .alarm        (alarm),
        .attempt_done (attempt_done),
        .attempt_ok   (attempt_ok),
        .fail_count   (fail_count)
    );

    always #5 clk = ~clk;

    // Behavioural serial lock.
    logic [6:0] lk_sec = DEF_SECRET;
    int         lk_cnt;
    logic       lk_err, lk_unl;
    int         lk_rec;
    always @(posedge clk or negedge lock_rstn) begin
        if (!lock_rstn) begin
            lk_cnt <= 0; lk_err <= 1'b0; lk_unl <= 1'b0; lk_rec <= 0;
        end else if (lk_unl) begin
            lk_unl <= 1'b1;
        end else if (lk_err) begin
            if (lk_rec == 1) begin lk_err <= 1'b0; lk_cnt <= 0; end
            else lk_rec <= lk_rec + 1;
        end else if (lock_in == lk_sec[6-lk_cnt]) begin
            if (lk_cnt == 6) lk_unl <= 1'b1;
            else lk_cnt <= lk_cnt + 1;
        end else begin
            lk_err <= 1'b1; lk_rec <= 0;
        end
    end
    assign lock_error  = lk_err;
    assign lock_unlock = lk_unl;

    logic [8:0] outs;
    assign outs = {cif.code_ready, lock_rstn, lock_in, unlocked, alarm,
                   attempt_done, attempt_ok, fail_count};

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        cif.code_valid = 1'b0; cif.code_data = '0; relock = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        tick();
    endtask

    // Returns at E0+#1 (first SEND cycle).
    task automatic offer(input logic [6:0] c);
        cif.code_valid = 1'b1; cif.code_data = c;
        tick();
        cif.code_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; cif.code_valid = 1'b0; relock = 1'b0;
        #3;
        total++;
        if (outs !== 9'b1_0000_0000) begin
            bad++; $display("FAIL reset_outs got=%b exp=%b", outs, 9'b1_0000_0000);
        end
        do_reset();
        total++;
        if (cif.code_ready !== 1'b1 || lock_rstn !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset ready=%b rstn=%b exp ready=1 rstn=0",
                            cif.code_ready, lock_rstn);
        end
    endtask

    task automatic test_correct();
        logic [6:0] seq;
        int n, dn;
        logic rst_ok;
        do_reset();
        offer(DEF_SECRET);
        rst_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            seq[6-i] = lock_in;
            if (lock_rstn !== 1'b1) rst_ok = 1'b0;
            tick();
        end
        total++;
        if (seq !== 7'b1011000 || !rst_ok) begin
            bad++; $display("FAIL correct_seq got=%b rstn_ok=%b exp=1011000 rstn_ok=1", seq, rst_ok);
        end
        total++;
        if (attempt_done !== 1'b0 || unlocked !== 1'b0) begin
            bad++; $display("FAIL correct_check_cycle done=%b unl=%b exp 0 0", attempt_done, unlocked);
        end
        tick();
        total++;
        if ({attempt_done, attempt_ok, unlocked, fail_count} !== 5'b11100) begin
            bad++; $display("FAIL correct_judge got=%b exp=11100",
                            {attempt_done, attempt_ok, unlocked, fail_count});
        end
        n = 0; dn = 0;
        while (unlocked === 1'b1 && n < 100) begin
            n++;
            if (attempt_done === 1'b1) dn++;
            tick();
        end
        total++;
        if (n !== 16 || dn !== 1) begin
            bad++; $display("FAIL open_len got=%0d pulses=%0d exp=16 pulses=1", n, dn);
        end
        total++;
        if (lock_rstn !== 1'b0 || cif.code_ready !== 1'b1) begin
            bad++; $display("FAIL open_exit rstn=%b ready=%b exp 0 1", lock_rstn, cif.code_ready);
        end
    endtask

    task automatic test_wrong_first();
        do_reset();
        offer(7'b0000000);
        tick();
        total++;
        if (lock_rstn !== 1'b1 || attempt_done !== 1'b0 || lock_error !== 1'b1) begin
            bad++; $display("FAIL wf_e1 rstn=%b done=%b err=%b exp 1 0 1",
                            lock_rstn, attempt_done, lock_error);
        end
        tick();
        total++;
        if ({attempt_done, attempt_ok, fail_count, lock_rstn, cif.code_ready} !== 6'b100101) begin
            bad++; $display("FAIL wf_judge got=%b exp=100101",
                            {attempt_done, attempt_ok, fail_count, lock_rstn, cif.code_ready});
        end
    endtask

    task automatic test_wrong_last();
        do_reset();
        offer(7'b1011001);
        repeat (7) tick();
        total++;
        if (attempt_done !== 1'b0 || lock_rstn !== 1'b1) begin
            bad++; $display("FAIL wl_send done=%b rstn=%b exp 0 1", attempt_done, lock_rstn);
        end
        tick();
        total++;
        if ({attempt_done, attempt_ok, fail_count, lock_rstn, unlocked} !== 6'b100100) begin
            bad++; $display("FAIL wl_judge got=%b exp=100100",
                            {attempt_done, attempt_ok, fail_count, lock_rstn, unlocked});
        end
    endtask

    // Three wrong codes from the current (fail_count==0) IDLE, then measure
    // the alarm window while offering ignored codes early in it.
    task automatic run_lockout(input int exp_len, input string tag);
        int n;
        logic held;
        for (int a = 0; a < 3; a++) begin
            offer(7'b0000000);
            tick(); tick();
        end
        total++;
        if ({alarm, cif.code_ready, fail_count} !== 4'b1011) begin
            bad++; $display("FAIL %s_entry got=%b exp=1011", tag, {alarm, cif.code_ready, fail_count});
        end
        n = 0; held = 1'b1;
        while (alarm === 1'b1 && n < 1000) begin
            n++;
            cif.code_valid = (n <= 10);
            cif.code_data  = DEF_SECRET;
            if (lock_rstn !== 1'b0) held = 1'b0;
            tick();
        end
        cif.code_valid = 1'b0;
        total++;
        if (n !== exp_len || !held) begin
            bad++; $display("FAIL %s_len got=%0d held=%b exp=%0d held=1", tag, n, held, exp_len);
        end
        total++;
        if ({fail_count, cif.code_ready, lock_rstn} !== 4'b0010) begin
            bad++; $display("FAIL %s_exit got=%b exp=0010", tag, {fail_count, cif.code_ready, lock_rstn});
        end
    endtask

    task automatic test_lockout();
        do_reset();
        run_lockout(64, "lockout1");
`ifdef LOCKOUT_ESCALATE_EN
        run_lockout(128, "lockout2");
`endif
    endtask

    task automatic test_relock();
        do_reset();
        offer(DEF_SECRET);
        repeat (10) tick();
        total++;
        if (unlocked !== 1'b1) begin
            bad++; $display("FAIL relock_pre got=%b exp=1", unlocked);
        end
        relock = 1'b1;
        tick();
        relock = 1'b0;
        total++;
        if ({unlocked, cif.code_ready, lock_rstn} !== 3'b010) begin
            bad++; $display("FAIL relock_early got=%b exp=010", {unlocked, cif.code_ready, lock_rstn});
        end
        do_reset();
        offer(DEF_SECRET);
        repeat (23) tick();
        total++;
        if (unlocked !== 1'b1) begin
            bad++; $display("FAIL relock_last_cycle got=%b exp=1", unlocked);
        end
        relock = 1'b1;
        tick();
        relock = 1'b0;
        total++;
        if ({unlocked, cif.code_ready} !== 2'b01) begin
            bad++; $display("FAIL relock_coinc got=%b exp=01", {unlocked, cif.code_ready});
        end
        tick();
        total++;
        if ({unlocked, alarm, attempt_done, cif.code_ready, lock_rstn} !== 5'b00010) begin
            bad++; $display("FAIL relock_settle got=%b exp=00010",
                            {unlocked, alarm, attempt_done, cif.code_ready, lock_rstn});
        end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        offer(7'b0000000);
        tick(); tick();
        total++;
        if (fail_count !== 2'd1) begin
            bad++; $display("FAIL rms_pre_fail got=%0d exp=1", fail_count);
        end
        offer(DEF_SECRET);
        repeat (3) tick();
        total++;
        if (lock_rstn !== 1'b1) begin
            bad++; $display("FAIL rms_sending got=%b exp=1", lock_rstn);
        end
        #2 resetn = 1'b0;
        #1;
        total++;
        if (outs !== 9'b1_0000_0000) begin
            bad++; $display("FAIL rms_async got=%b exp=%b", outs, 9'b1_0000_0000);
        end
        do_reset();
    endtask

    initial begin
        cif.code_valid = 1'b0;
        cif.code_data  = '0;
        test_reset();
        test_correct();
        test_wrong_first();
        test_wrong_last();
        test_lockout();
        test_relock();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
